sync_fifo_prog: RTL and testbench
=================================

// Module: sync_fifo_prog
// PURPOSE
//   Next-generation single-clock FIFO with programmable almost-full/almost-empty thresholds,
//   an occupancy count, selectable standard/first-word-fall-through (FWFT) read mode,
//   synchronous flush and sticky error flags. It is the general buffering element between
//   producer/consumer pipelines in one clock domain.
// PARAMETERS
//   DATA_WIDTH  8     width of each stored word
//   DEPTH       16    number of entries; power of two, >= 4
//   ADDR_WIDTH  4     $clog2(DEPTH); pointer index width
//   AF_LEVEL    14    almost_full_o asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    2     almost_empty_o asserts when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT        0     0 = standard registered read; 1 = first-word-fall-through
// PORTS
//   clk_i           in   1             clock, all state on rising edge
//   rst_i           in   1             asynchronous, active-high reset
//   flush_i         in   1             synchronous flush; empties FIFO on next edge
//   wr_en_i         in   1             write request
//   wr_data_i       in   DATA_WIDTH    write data, sampled with wr_en_i
//   full_o          out  1             count == DEPTH
//   almost_full_o   out  1             count >= AF_LEVEL
//   overflow_o      out  1             one-cycle pulse: write rejected on previous edge
//   rd_en_i         in   1             read request
//   rd_data_o       out  DATA_WIDTH    read data (timing per FWFT)
//   empty_o         out  1             count == 0
//   almost_empty_o  out  1             count <= AE_LEVEL
//   underflow_o     out  1             one-cycle pulse: read rejected on previous edge
//   count_o         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   clr_err_i       in   1             clears sticky error bits
//   err_sticky_o    out  2             {underflow seen, overflow seen}
// BEHAVIOUR
//   - Reset (async assert, state released on first edge after deassert): wr/rd pointers=0,
//     count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, overflow_o=0,
//     underflow_o=0, err_sticky_o=0, rd_data_o=0. Storage array is not reset.
//   - Write accepted iff wr_en_i && !full_o; read accepted iff rd_en_i && !empty_o.
//     Acceptance uses flags from before the edge. There is no full-pass-through.
//   - Both requests accepted in the same cycle: count unchanged, both pointers advance.
//   - Full with wr_en_i && rd_en_i: read accepted, write rejected -> overflow_o pulse.
//   - Empty with wr_en_i && rd_en_i: write accepted, read rejected -> underflow_o pulse.
//   - Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally. count_o is ADDR_WIDTH+1 bits.
//   - full_o, empty_o, almost_* and count_o are registered or decoded only from registered
//     count. They reflect an accepted operation one cycle after its edge.
//   - FWFT=0: rd_data_o is registered. It is loaded with the head word on the edge that
//     accepts a read, so data is valid the cycle after rd_en_i. It holds otherwise.
//   - FWFT=1: rd_data_o always shows the head entry. Value is don't-care while empty_o=1.
//     A read accepted on an edge pops that word, and the next entry appears after the edge.
//     A write into an empty FIFO is visible on rd_data_o the cycle after the write edge.
//   - overflow_o/underflow_o: high for exactly one cycle after a rejected request edge.
//     Each rejected cycle in a run produces its own pulse.
//   - err_sticky_o[0]/[1] set with the overflow/underflow pulse and hold until clr_err_i.
//     If set and clear occur in the same cycle, set wins.
//   - flush_i has priority over wr/rd on its edge: pointers=0, count=0.
//     No overflow/underflow pulse is generated that cycle. rd_data_o and err_sticky_o hold.
//   - Reset mid-operation: all state returns to reset values immediately. Contents are discarded.
// TESTING
//   - Reset with FWFT=0: empty_o=1, almost_empty_o=1, count_o=0, all other outputs 0.
//   - Fill: write 16 words 0x10..0x1F.
//     almost_full_o rises when count_o=14. full_o rises when count_o=16.
//     A 17th write gives overflow_o for 1 cycle, err_sticky_o=2'b01, count stays 16.
//   - Drain, FWFT=0: 16 reads return 0x10..0x1F, each one cycle after rd_en_i.
//     almost_empty_o rises at count 2. A 17th read gives underflow_o and err_sticky_o=2'b11.
//     clr_err_i then gives 2'b00.
//   - Simultaneous operation: at count 8, wr+rd for 20 cycles keeps count_o=8.
//     Data order is preserved across pointer wrap.
//     With full and wr+rd: read ok, overflow pulse. With empty and wr+rd: count->1, underflow pulse.
//   - FWFT=1: write 0xA5 to empty; rd_data_o=0xA5 the next cycle with no rd_en_i.
//     Write 0x5A, read once, and rd_data_o becomes 0x5A.
//   - Flush at count 9 with wr_en_i=1: next cycle count_o=0, empty_o=1, no overflow.
//     Async reset asserted mid-burst clears all flags at once.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels,
// occupancy count, standard or first-word-fall-through read data,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic                  underflow_o,
    output logic [ADDR_WIDTH:0]   count_o,
    input  logic                  clr_err_i,
    output logic [1:0]            err_sticky_o
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [1:0]            err_q, err_d;

    logic                  full, empty;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] head;

    // All status flags decode only the registered count.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Acceptance uses the flags as they stood before the edge.
    assign wr_acc = wr_en_i && !full;
    assign rd_acc = rd_en_i && !empty;

    // Next-state for pointers, count, read register and error flags.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        err_d     = clr_err_i ? 2'b00 : err_q;
        if (flush_i) begin
            // Flush beats any request on this edge; no error pulses.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
            if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
            if (rd_acc && FWFT == 0) rd_data_d = head;
            ovf_d = wr_en_i && !wr_acc;
            unf_d = rd_en_i && !rd_acc;
        end
        // A new error in the same cycle as a clear still latches.
        err_d = err_d | {unf_d, ovf_d};
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            err_q     <= err_d;
        end
    end

    // Storage array; not reset, written only on accepted non-flush writes.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign err_sticky_o   = err_q;
    // FWFT shows the head directly (forced to zero while empty).
    assign rd_data_o      = (FWFT != 0) ? (empty ? '0 : head) : rd_data_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a standard-read instance driven through
// fill/drain/simultaneous/flush/reset sequences, plus an FWFT instance.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, wr_en, rd_en, clr_err;
    logic [7:0] wr_data;
    logic       full, afull, ovf, empty, aempty, unf;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic [1:0] err;

    logic       f_wr_en, f_rd_en;
    logic [7:0] f_wr_data;
    logic       f_full, f_afull, f_ovf, f_empty, f_aempty, f_unf;
    logic [7:0] f_rd_data;
    logic [4:0] f_count;
    logic [1:0] f_err;

    int passed = 0;
    int total  = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_rd;

    always #5 clk = ~clk;

    sync_fifo_prog #(.FWFT(0)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .wr_en_i(wr_en), .wr_data_i(wr_data),
        .full_o(full), .almost_full_o(afull), .overflow_o(ovf),
        .rd_en_i(rd_en), .rd_data_o(rd_data),
        .empty_o(empty), .almost_empty_o(aempty), .underflow_o(unf),
        .count_o(count), .clr_err_i(clr_err), .err_sticky_o(err)
    );

    sync_fifo_prog #(.FWFT(1)) dut_f (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .wr_en_i(f_wr_en), .wr_data_i(f_wr_data),
        .full_o(f_full), .almost_full_o(f_afull), .overflow_o(f_ovf),
        .rd_en_i(f_rd_en), .rd_data_o(f_rd_data),
        .empty_o(f_empty), .almost_empty_o(f_aempty), .underflow_o(f_unf),
        .count_o(f_count), .clr_err_i(1'b0), .err_sticky_o(f_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = 0;
    endtask

    initial begin
        rst = 1; idle();
        f_wr_en = 0; f_rd_en = 0; f_wr_data = 0;
        exp_rd = 8'h00;
        step(); step();
        chk("rst_empty", empty, 1);   chk("rst_aempty", aempty, 1);
        chk("rst_count", count, 0);   chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);   chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);       chk("rst_err", err, 0);
        chk("rst_rdata", rd_data, 0);
        rst = 0;
        step();

        // FWFT: a write into empty is visible the next cycle without a read.
        f_wr_en = 1; f_wr_data = 8'hA5;
        step();
        chk("fwft_first", f_rd_data, 8'hA5);
        chk("fwft_notempty", f_empty, 0);
        f_wr_data = 8'h5A;
        step();
        f_wr_en = 0; f_rd_en = 1;
        step();
        chk("fwft_second", f_rd_data, 8'h5A);
        chk("fwft_count", f_count, 1);
        f_rd_en = 0;
        step();

        // Fill with 0x10..0x1F.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_data = 8'(8'h10 + i); sb.push_back(wr_data);
            step();
            chk("fill_count", count, i + 1);
            chk("fill_afull", afull, (i + 1 >= 14));
            chk("fill_full", full, (i + 1 == 16));
        end
        wr_data = 8'hEE;
        step();
        chk("ovf_pulse", ovf, 1); chk("ovf_err", err, 2'b01); chk("ovf_count", count, 16);
        idle();
        step();
        chk("ovf_once", ovf, 0);

        // Drain; data arrives the cycle after rd_en.
        for (int i = 0; i < 16; i++) begin
            rd_en = 1; exp_rd = sb.pop_front();
            step();
            chk("drain_data", rd_data, exp_rd);
            chk("drain_count", count, 15 - i);
            chk("drain_aempty", aempty, (15 - i <= 2));
        end
        step();
        chk("unf_pulse", unf, 1); chk("unf_err", err, 2'b11);
        chk("unf_hold", rd_data, exp_rd);
        idle(); clr_err = 1;
        step();
        chk("clr_err", err, 0); chk("unf_once", unf, 0);
        clr_err = 0;

        // Simultaneous wr+rd at count 8, across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_data = 8'(8'h30 + i); sb.push_back(wr_data);
            step();
        end
        chk("sim_start", count, 8);
        for (int i = 0; i < 20; i++) begin
            wr_en = 1; rd_en = 1; wr_data = 8'(8'h40 + i);
            sb.push_back(wr_data); exp_rd = sb.pop_front();
            step();
            chk("sim_data", rd_data, exp_rd);
            chk("sim_count", count, 8);
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; exp_rd = sb.pop_front();
            step();
            chk("sim_drain", rd_data, exp_rd);
        end
        idle();
        chk("sim_empty", empty, 1);

        // Full with wr+rd: read accepted, write rejected.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_data = 8'(8'h50 + i); sb.push_back(wr_data);
            step();
        end
        wr_en = 1; rd_en = 1; wr_data = 8'h99; exp_rd = sb.pop_front();
        step();
        chk("fullrw_data", rd_data, exp_rd);
        chk("fullrw_ovf", ovf, 1);
        chk("fullrw_count", count, 15);
        idle(); clr_err = 1;
        for (int i = 0; i < 15; i++) begin
            rd_en = 1; exp_rd = sb.pop_front();
            step();
            clr_err = 0;
            chk("fullrw_drain", rd_data, exp_rd);
        end
        chk("fullrw_clr", err, 0);

        // Empty with wr+rd: write accepted, read rejected.
        wr_en = 1; rd_en = 1; wr_data = 8'h77; sb.push_back(wr_data);
        step();
        chk("emptyrw_unf", unf, 1);
        chk("emptyrw_count", count, 1);
        chk("emptyrw_hold", rd_data, exp_rd);
        chk("emptyrw_err", err, 2'b10);
        idle(); rd_en = 1; exp_rd = sb.pop_front();
        step();
        chk("emptyrw_data", rd_data, exp_rd);
        idle(); clr_err = 1;
        step();
        clr_err = 0;

        // Flush at count 9 while writing.
        for (int i = 0; i < 9; i++) begin
            wr_en = 1; wr_data = 8'(8'h60 + i);
            step();
        end
        chk("flush_pre", count, 9);
        flush = 1; wr_en = 1; wr_data = 8'hCC;
        step();
        chk("flush_count", count, 0); chk("flush_empty", empty, 1);
        chk("flush_ovf", ovf, 0);     chk("flush_rdata", rd_data, exp_rd);
        chk("flush_err", err, 0);
        idle();
        step();
        chk("flush_idle", count, 0);

        // Async reset mid-burst right after an overflow.
        for (int i = 0; i < 17; i++) begin
            wr_en = 1; wr_data = 8'(8'h80 + i);
            step();
        end
        chk("burst_ovf", ovf, 1); chk("burst_full", full, 1);
        #2 rst = 1;
        #1;
        chk("arst_count", count, 0); chk("arst_full", full, 0);
        chk("arst_afull", afull, 0); chk("arst_ovf", ovf, 0);
        chk("arst_err", err, 0);     chk("arst_empty", empty, 1);
        chk("arst_rdata", rd_data, 0);
        idle();
        step();
        rst = 0;
        step();
        chk("post_rst_count", count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
